// File: rtl/piso5bit_tx.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word on start/ready and
// shifts it out MSB-first with valid framing and a one-cycle done pulse.
module piso5bit_tx #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             last_bit;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    last_bit = (state_q == SHIFT) && (cnt_q == LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end else if (start) begin
          // back-to-back reload on the last bit: no gap cycle, no done
          shreg_d = data;
          cnt_d   = '0;
        end else begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE) || last_bit;
  assign busy  = (state_q == SHIFT);
  assign valid = (state_q == SHIFT);
  assign sout  = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign done  = done_q;

endmodule

// File: tb/tb_piso5bit_tx.sv
// Bench for piso5bit_tx: scoreboard of expected serial bits plus a 5-bit
// receiver model, table-driven single words and hand-written corner cases.
module tb_piso5bit_tx;

  logic       clk = 1'b0;
  logic       clear;
  logic [4:0] data;
  logic       start;
  logic       ready, busy, sout, valid, done;
  logic [7:0] data8;
  logic       start8;
  logic       ready8, busy8, sout8, valid8, done8;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic exp_q[$];
  logic [4:0] rx = '0;
  logic [4:0] exp_rx = '0;

  always #5 clk = ~clk;

  piso5bit_tx #(.WIDTH(5)) dut (
    .clk(clk), .clear(clear), .data(data), .start(start),
    .ready(ready), .busy(busy), .sout(sout), .valid(valid), .done(done)
  );

  piso5bit_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .data(data8), .start(start8),
    .ready(ready8), .busy(busy8), .sout(sout8), .valid(valid8), .done(done8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid cycle consumes one expected bit; receiver checked on done.
  always @(negedge clk) begin
    if (valid && done) chk("valid_and_done", 1, 0);
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        chk("sout_bit", sout, e);
      end
      rx = {rx[3:0], sout};
    end
    if (done) begin
      done_cnt++;
      chk("rx_word_at_done", rx, exp_rx);
    end
  end

  task automatic push_word(input logic [4:0] w);
    for (int i = 4; i >= 0; i--) exp_q.push_back(w[i]);
    exp_rx = w;
  endtask

  // Call right after a posedge #1; the next posedge is the load edge.
  task automatic send_word(input logic [4:0] w);
    push_word(w);
    data  = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20 && done_cnt < target; i++) @(posedge clk);
    #1;
    chk("done_count", done_cnt, target);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [4:0] din;
    logic [4:0] rx_exp;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] bits8;
  int base;

  initial begin
    vecs[0] = '{5'b10110, 5'b10110};
    vecs[1] = '{5'b10001, 5'b10001};
    vecs[2] = '{5'b00000, 5'b00000};
    vecs[3] = '{5'b11111, 5'b11111};
    vecs[4] = '{5'b00001, 5'b00001};

    clear  = 1'b0;
    start  = 1'b1;
    data   = 5'b11111;
    start8 = 1'b0;
    data8  = '0;

    // Reset held for 3 edges with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy",  busy,  0);
      chk("rst_valid", valid, 0);
      chk("rst_sout",  sout,  0);
      chk("rst_done",  done,  0);
    end
    chk("rst_ready8", ready8, 1);
    chk("rst_valid8", valid8, 0);
    @(posedge clk); #1;
    start = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst_busy", busy, 0);

    // Table-driven single words
    foreach (vecs[i]) begin
      base = done_cnt;
      push_word(vecs[i].din);
      exp_rx = vecs[i].rx_exp;
      data  = vecs[i].din;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_load", busy, 1);
      wait_done(base + 1);
      chk("done_one_cycle", done, 0);
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
    end

    // Single word returns to IDLE WIDTH+1 cycles after the load edge
    send_word(5'b10110);
    repeat (4) @(posedge clk);
    #1;
    chk("last_bit_ready", ready, 1);
    chk("last_bit_valid", valid, 1);
    @(posedge clk); #1;
    chk("done_cycle", done, 1);
    chk("done_cycle_busy", busy, 0);
    @(posedge clk); #1;
    chk("post_done", done, 0);

    // Back-to-back reload on the last bit
    base = done_cnt;
    push_word(5'b11000);
    push_word(5'b00111);
    data  = 5'b11000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    data  = 5'b00111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_no_gap_valid", valid, 1);
    chk("b2b_no_gap_sout", sout, 0);
    chk("b2b_no_early_done", done_cnt, base);
    wait_done(base + 1);
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_single_done", done_cnt, base + 1);

    // Start while busy is ignored
    base = done_cnt;
    push_word(5'b01010);
    data  = 5'b01010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_not_ready", ready, 0);
    data  = 5'b11111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(base + 1);
    repeat (8) @(posedge clk);
    #1;
    chk("reject_no_second_word", done_cnt, base + 1);

    // Asynchronous reset during the 3rd bit
    base = done_cnt;
    send_word(5'b11111);
    @(posedge clk); #1;
    @(posedge clk); #2;
    clear = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_sout", sout, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt, base);
    send_word(5'b10001);
    wait_done(base + 1);

    // WIDTH = 8 instance
    bits8  = 8'hA5;
    data8  = 8'hA5;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      chk("w8_valid", valid8, 1);
      chk("w8_sout", sout8, bits8[k]);
      chk("w8_no_done", done8, 0);
    end
    @(negedge clk);
    chk("w8_done", done8, 1);
    chk("w8_valid_end", valid8, 0);
    @(negedge clk);
    chk("w8_done_pulse", done8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1);
  end

endmodule

// File: doc/piso5bit_tx.md
# piso5bit_tx

Parallel-in, serial-out shift transmitter: the sending end of the team's 5-bit serial-in shift register link. It accepts a WIDTH-bit word on a ready/start handshake and shifts it out MSB-first, one bit per clock. It frames the bits with `valid` and signals completion with a one-cycle `done` pulse. Its `sout` drives the serial `in` of the receiving shift register directly; with WIDTH = 5, the receiver's outputs a..e equal data[4:0] in the cycle `done` is high.

## Interface
- `WIDTH`, default 5, word length in bits (≥ 2)
- `clk`  input  1  clock; all state changes on the rising edge
- `clear`  input  1  asynchronous, active-low reset (0 = reset, takes effect immediately, independent of `clk`)
- `data`  input  WIDTH  parallel word; sampled only on an accepted load edge
- `start`  input  1  load request; accepted on a rising edge where `start` = 1 and `ready` = 1
- `ready`  output  1  transmitter can accept a word this cycle (combinational)
- `busy`  output  1  a word is being shifted (state SHIFT)
- `sout`  output  1  serial bit; equals shreg[WIDTH-1] when `valid` = 1, else 0
- `valid`  output  1  `sout` carries a data bit this cycle
- `done`  output  1  one-cycle pulse after the last bit of a word with no reload

## Operation
- Internal state: `state` ∈ {IDLE, SHIFT}, `shreg[WIDTH-1:0]`, `cnt` (ceil(log2 WIDTH) bits), registered `done`.
- Reset (`clear` = 0): state = IDLE, shreg = 0, cnt = 0, done = 0. During and after reset: ready = 1, busy = 0, valid = 0, sout = 0.
- `ready` = (state == IDLE) or (state == SHIFT and cnt == WIDTH-1).
- `busy` = `valid` = (state == SHIFT).
- IDLE, edge with `start` = 1: shreg ← data, cnt ← 0, state ← SHIFT, done ← 0. With `start` = 0: no change, and done ← 0.
- SHIFT, edge with cnt < WIDTH-1: shreg ← {shreg[WIDTH-2:0], 0}, cnt ← cnt+1. `start` is ignored here and `data` is not captured.
- SHIFT, edge with cnt == WIDTH-1 (last bit) and `start` = 1: reload back-to-back. shreg ← data, cnt ← 0, stay in SHIFT, done ← 0. There is no gap cycle.
- SHIFT, edge with cnt == WIDTH-1 and `start` = 0: state ← IDLE, shreg ← 0, cnt ← 0, done ← 1.
- Bit order: cycle k after load (k = 0..WIDTH-1) presents data[WIDTH-1-k] on `sout`.
- Reset mid-word: the word is abandoned immediately. No `done` is issued, and the next word needs a fresh `start` after `clear` returns to 1.

## Timing
- Load edge L: `sout` = data[WIDTH-1] and `valid` = 1 in the cycle after L.
- The last bit, data[0], appears in the cycle after edge L+WIDTH-1.
- `done` = 1 for exactly the cycle after edge L+WIDTH, and only when no reload occurred.
- A receiver sampling `sout` on rising edges L+1..L+WIDTH holds the full word in that same cycle.
- Throughput: one word per WIDTH cycles with continuous `start`.
- Single word, no reload: WIDTH+1 cycles from the load edge back to IDLE.
- `done` and `valid` are never 1 in the same cycle.
- `ready` changes only after `clk` edges or `clear`.

## Test plan
- Reset: hold `clear` = 0 for 3 edges with `start` = 1 and data = 5'b11111. Required: ready = 1, busy = 0, valid = 0, sout = 0, done = 0 throughout; nothing is loaded.
- Single word, WIDTH = 5, data = 5'b10110, one-cycle `start`. Required: `sout` = 1,0,1,1,0 on 5 consecutive valid cycles, then `done` = 1 for one cycle, then IDLE. A chained 5-bit receiver reads a..e = 1,0,1,1,0 in the `done` cycle.
- Back-to-back: load 5'b11000, then hold `start` = 1 with data = 5'b00111 during the last bit. Required: 10 contiguous valid bits 1,1,0,0,0,0,0,1,1,1; `done` pulses once, after the 10th bit.
- Busy rejection: pulse `start` with data = 5'b11111 at cnt = 2 during word 5'b01010. Required: the output stays 0,1,0,1,0 and no second word is sent.
- Reset mid-word: drive `clear` = 0 asynchronously (between edges) during the 3rd bit of 5'b11111. Required: valid = 0 and sout = 0 immediately, done = 0, state IDLE; a subsequent word 5'b10001 transmits correctly.
- WIDTH = 8, data = 8'hA5. Required: `sout` = 1,0,1,0,0,1,0,1, and `done` is in the cycle after edge L+8.
